// File: rtl/sha256_stream_bridge.sv
// sha256_stream_bridge: byte-stream front end for a SHA-256 core.
// Input bytes are buffered in a FIFO and fed to the core. The digest is
// captured, then streamed out in OUT_BYTES-wide beats under valid/ready.
// Optional feature macro: SHA256_BRIDGE_OVF_EN enables the sticky ovf flag.
// Also contains sha256_processor, a byte-fed SHA-256 core that does its own padding.

module sha256_processor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         data_valid,
  input  logic         data_last,
  input  logic [7:0]   data_in,
  output logic         in_ready,
  output logic         done,
  output logic [255:0] hash_out
);
  typedef enum logic [2:0] {C_IDLE, C_LOAD, C_PAD, C_COMP, C_DONE} core_state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  core_state_t  state, state_next;
  logic [511:0] blk;
  logic [6:0]   cnt;
  logic [60:0]  byte_len;
  logic         msg_end, seen80, len_done;
  logic [5:0]   round;
  logic [31:0]  hh [8];
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  t1, t2, new_w;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign hash_out = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= C_IDLE;
    else     state <= state_next;
  end

  // Next state: load bytes, pad once the message ends, compress each full block.
  always_comb begin
    state_next = state;
    case (state)
      C_IDLE: if (start && data_valid) state_next = data_last ? C_PAD : C_LOAD;
      C_LOAD: if (data_valid) begin
        if (cnt == 7'd63)   state_next = C_COMP;
        else if (data_last) state_next = C_PAD;
      end
      C_PAD: if ((!seen80 && cnt == 7'd63) || (seen80 && (cnt == 7'd56 || cnt == 7'd63)))
        state_next = C_COMP;
      C_COMP: if (round == 6'd63) begin
        if (!msg_end)      state_next = C_LOAD;
        else if (len_done) state_next = C_DONE;
        else               state_next = C_PAD;
      end
      C_DONE: state_next = C_IDLE;
      default: state_next = C_IDLE;
    endcase
  end

  // Handshake outputs; in_ready looks ahead so a byte in flight that ends a block or message stops the next pop.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state)
      C_IDLE: in_ready = !(data_valid && data_last);
      C_LOAD: in_ready = !(data_valid && (data_last || cnt == 7'd63));
      C_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // One compression round plus the rolling message-schedule word.
  always_comb begin
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[round] + blk[511:480];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    new_w = (rotr(blk[63:32], 17) ^ rotr(blk[63:32], 19) ^ (blk[63:32] >> 10)) + blk[223:192]
          + (rotr(blk[479:448], 7) ^ rotr(blk[479:448], 18) ^ (blk[479:448] >> 3)) + blk[511:480];
  end

  // Datapath: block shift register, byte counters, padding flags and the hash state.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk <= '0; cnt <= '0; byte_len <= '0; round <= '0;
      msg_end <= 1'b0; seen80 <= 1'b0; len_done <= 1'b0;
      for (int i = 0; i < 8; i++) hh[i] <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
    end else begin
      if (state != C_COMP) {a, b, c, d, e, f, g, h} <= {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
      case (state)
        C_IDLE: if (start && data_valid) begin
          for (int i = 0; i < 8; i++) hh[i] <= H0[i];
          blk <= {blk[503:0], data_in}; cnt <= 7'd1; byte_len <= 61'd1;
          msg_end <= data_last; seen80 <= 1'b0; len_done <= 1'b0;
        end
        C_LOAD: if (data_valid) begin
          blk <= {blk[503:0], data_in}; cnt <= cnt + 7'd1;
          byte_len <= byte_len + 61'd1; msg_end <= data_last;
        end
        C_PAD: begin
          if (!seen80) begin
            blk <= {blk[503:0], 8'h80}; cnt <= cnt + 7'd1; seen80 <= 1'b1;
          end else if (cnt == 7'd56) begin
            blk <= {blk[447:0], byte_len, 3'b000}; cnt <= 7'd64; len_done <= 1'b1;
          end else begin
            blk <= {blk[503:0], 8'h00}; cnt <= cnt + 7'd1;
          end
        end
        C_COMP: begin
          {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
          blk <= {blk[479:0], new_w};
          round <= round + 6'd1;
          if (round == 6'd63) begin
            hh[0] <= hh[0] + t1 + t2; hh[1] <= hh[1] + a; hh[2] <= hh[2] + b; hh[3] <= hh[3] + c;
            hh[4] <= hh[4] + d + t1;  hh[5] <= hh[5] + e; hh[6] <= hh[6] + f; hh[7] <= hh[7] + g;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module sha256_stream_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_BYTES  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             din,
  input  logic                   valid,
  input  logic                   last,
  output logic                   ready,
  output logic [8*OUT_BYTES-1:0] dout,
  output logic                   dvalid,
  input  logic                   dready,
  output logic                   busy,
  output logic                   ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = 8 * OUT_BYTES;
  localparam logic [5:0] LAST_BEAT = 6'(32 / OUT_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DUMP} bridge_state_t;

  bridge_state_t state, state_next;
  logic [8:0]   mem [FIFO_DEPTH];
  logic [AW:0]  wptr, rptr;
  logic [8:0]   head;
  logic         full, empty, push, pop, closed;
  logic         core_start, core_valid, core_last, core_in_ready, core_done;
  logic [7:0]   core_data;
  logic [255:0] core_hash, digest, shifted;
  logic [5:0]   beat;
  logic         final_beat;

  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty      = (wptr == rptr);
  assign ready      = !full && !closed;
  assign push       = valid && ready;
  assign head       = mem[rptr[AW-1:0]];
  assign final_beat = dvalid && dready && (beat == LAST_BEAT);

  sha256_processor core (
    .clk(clk), .rst(rst), .start(core_start), .data_valid(core_valid), .data_last(core_last),
    .data_in(core_data), .in_ready(core_in_ready), .done(core_done), .hash_out(core_hash)
  );

  // Bridge state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state: feed the message, wait for the core, then dump the digest.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (pop) state_next = head[8] ? S_WAIT : S_FEED;
      S_FEED: if (pop && head[8]) state_next = S_WAIT;
      S_WAIT: if (core_done) state_next = S_DUMP;
      S_DUMP: if (final_beat) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: pop one FIFO entry per cycle while feeding, and flag digest beats in DUMP.
  always_comb begin
    pop    = (state == S_IDLE || state == S_FEED) && !empty && core_in_ready;
    dvalid = (state == S_DUMP);
  end

  // Select the current beat from the digest register, most significant beat first.
  always_comb begin
    shifted = digest << (32'(beat) * OW);
    dout    = shifted[255 -: OW];
  end

  // FIFO storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {last, din};
  end

  // Pointers, message flags, registered core inputs, digest capture and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0; rptr <= '0; closed <= 1'b0; busy <= 1'b0;
      core_start <= 1'b0; core_valid <= 1'b0; core_last <= 1'b0; core_data <= '0;
      digest <= '0; beat <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
        busy <= 1'b1;
        if (last) closed <= 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      core_start <= pop && (state == S_IDLE);
      core_valid <= pop;
      core_last  <= pop && head[8];
      core_data  <= head[7:0];
      if (state == S_WAIT && core_done) begin
        digest <= core_hash;
        beat   <= '0;
      end
      if (dvalid && dready) beat <= final_beat ? 6'd0 : beat + 6'd1;
      if (final_beat) begin
        closed <= 1'b0;
        busy   <= 1'b0;
      end
    end
  end

`ifdef SHA256_BRIDGE_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;

  // Sticky flag for any byte offered while the bridge was not accepting.
  always_ff @(posedge clk) begin
    if (rst)                 ovf_q <= 1'b0;
    else if (valid && !ready) ovf_q <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif
endmodule
